// File: rtl/misr_pkg.sv
// ---------------------------------------------------------------------------
// misr_pkg
//   Shared definitions for the BIST response compactors.
//   - misr_state_e : FSM state encoding of the compactor control.
//   - ARB_BIST_*   : default feedback taps and seed for the 16-bit arbiter
//                    BIST signature register.
// ---------------------------------------------------------------------------
package misr_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPACT = 2'd1,
      DONE    = 2'd2,
      UNLOAD  = 2'd3
   } misr_state_e;

   localparam logic [15:0] ARB_BIST_POLY = 16'hD008;
   localparam logic [15:0] ARB_BIST_SEED = 16'hFFFF;

endpackage

// File: rtl/misr_step.sv
// ---------------------------------------------------------------------------
// misr_step
//   Combinational next-signature function of a multiple-input signature
//   register:
//     nxt[i] = sig[i-1] (0 for i==0) ^ (POLY[i] & sig[SIG_W-1])
//              ^ data[IN_W-1-i] (only for i < IN_W)
//   The MSB of the response vector lands in signature bit 0.
// Ports
//   sig_i   in  SIG_W  current signature
//   data_i  in  IN_W   parallel response vector
//   nxt_o   out SIG_W  next signature
// ---------------------------------------------------------------------------
module misr_step #(
   parameter int               SIG_W = 16,
   parameter int               IN_W  = 4,
   parameter logic [SIG_W-1:0] POLY  = misr_pkg::ARB_BIST_POLY
) (
   input  logic [SIG_W-1:0] sig_i,
   input  logic [IN_W-1:0]  data_i,
   output logic [SIG_W-1:0] nxt_o
);

   logic msb;
   assign msb = sig_i[SIG_W-1];

   // Bit 0 has no shift-in from below; IN_W >= 1 so it always takes a data bit.
   assign nxt_o[0] = (POLY[0] & msb) ^ data_i[IN_W-1];

   for (genvar i = 1; i < SIG_W; i++) begin : g_bit
      if (i < IN_W) begin : g_with_data
         assign nxt_o[i] = sig_i[i-1] ^ (POLY[i] & msb) ^ data_i[IN_W-1-i];
      end else begin : g_no_data
         assign nxt_o[i] = sig_i[i-1] ^ (POLY[i] & msb);
      end
   end

endmodule

// File: rtl/misr_compactor.sv
// ---------------------------------------------------------------------------
// misr_compactor
//   BIST response compactor for the arbiter. From SEED it folds IN_W response
//   bits into the signature on every valid cycle, for NUM_VECTORS vectors,
//   then compares against GOLDEN and reports pass/fail. The signature can be
//   unloaded serially (MSB first) on the scan chain afterwards.
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   start      in   1      begin/restart a run, reseeds the signature
//   data_in    in   IN_W   response vector
//   data_valid in   1      data_in is compacted this cycle
//   shift_en   in   1      serial unload enable (DONE/UNLOAD only)
//   scan_in    in   1      serial input into signature bit 0 during unload
//   scan_out   out  1      signature MSB
//   signature  out  SIG_W  signature register
//   busy       out  1      compaction in progress
//   done       out  1      run complete, pass/fail valid
//   pass       out  1      final signature == GOLDEN
//   fail       out  1      final signature != GOLDEN
// Handshake: data_valid is a qualifier with no back-pressure. A vector is
// consumed on every rising edge where busy=1, start=0 and data_valid=1;
// vectors presented while busy=0 are dropped.
// ---------------------------------------------------------------------------
module misr_compactor
   import misr_pkg::*;
#(
   parameter int               SIG_W       = 16,
   parameter int               IN_W        = 4,
   parameter logic [SIG_W-1:0] POLY        = ARB_BIST_POLY,
   parameter logic [SIG_W-1:0] SEED        = ARB_BIST_SEED,
   parameter logic [SIG_W-1:0] GOLDEN      = '0,
   parameter int               NUM_VECTORS = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IN_W-1:0]  data_in,
   input  logic             data_valid,
   input  logic             shift_en,
   input  logic             scan_in,
   output logic             scan_out,
   output logic [SIG_W-1:0] signature,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail
);

   localparam int              CNT_W = $clog2(NUM_VECTORS + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VECTORS - 1);

   misr_state_e      state_q;
   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q, done_q, pass_q, fail_q;

   misr_step #(
      .SIG_W (SIG_W),
      .IN_W  (IN_W),
      .POLY  (POLY)
   ) u_step (
      .sig_i  (sig_q),
      .data_i (data_in),
      .nxt_o  (sig_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sig_q   <= SEED;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else if (start) begin
         // start wins over data_valid and shift_en in every state.
         state_q <= COMPACT;
         sig_q   <= SEED;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         case (state_q)
            COMPACT: begin
               if (data_valid) begin
                  sig_q <= sig_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST) begin
                     // Compare the value being written so the verdict
                     // arrives together with done.
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (sig_d == GOLDEN);
                     fail_q  <= (sig_d != GOLDEN);
                  end
               end
            end
            DONE, UNLOAD: begin
               if (shift_en) begin
                  state_q <= UNLOAD;
                  sig_q   <= {sig_q[SIG_W-2:0], scan_in};
               end else begin
                  state_q <= DONE;
               end
            end
            default: ; // IDLE waits for start
         endcase
      end
   end

   assign scan_out  = sig_q[SIG_W-1];
   assign signature = sig_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail      = fail_q;

endmodule

// File: tb/tb_misr_compactor.sv
module tb_misr_compactor;

   // ---------------- clock / reset / shared stimulus ----------------
   logic       clk = 1'b0;
   logic       rst, start, data_valid, shift_en, scan_in;
   logic [3:0] data_in;

   always #5 clk = ~clk;

   // Instance A: single-vector runs, GOLDEN matches data 4'h8.
   logic        a_scan_out, a_busy, a_done, a_pass, a_fail;
   logic [15:0] a_sig;
   // Instance B: four-vector runs, default GOLDEN 16'h0000.
   logic        b_scan_out, b_busy, b_done, b_pass, b_fail;
   logic [15:0] b_sig;

   localparam logic [15:0] GOLDEN_B = 16'h0000;

   misr_compactor #(.NUM_VECTORS(1), .GOLDEN(16'h2FF7)) u_a (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in),
      .data_valid(data_valid), .shift_en(shift_en), .scan_in(scan_in),
      .scan_out(a_scan_out), .signature(a_sig), .busy(a_busy),
      .done(a_done), .pass(a_pass), .fail(a_fail)
   );

   misr_compactor #(.NUM_VECTORS(4), .GOLDEN(GOLDEN_B)) u_b (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in),
      .data_valid(data_valid), .shift_en(shift_en), .scan_in(scan_in),
      .scan_out(b_scan_out), .signature(b_sig), .busy(b_busy),
      .done(b_done), .pass(b_pass), .fail(b_fail)
   );

   // ---------------- scoreboard ----------------
   int          errors = 0;
   int          checks = 0;
   logic [15:0] m_sig;        // reference signature for instance B
   logic [15:0] exp_q[$];     // expected scan_out words for unload

   // Reference: multiply-by-x in GF(2) with reduction by the tap word, then
   // add the bit-reversed response vector into the low bits.
   function automatic logic [15:0] m_step(input logic [15:0] s, input logic [3:0] d);
      logic [15:0] r;
      r = s << 1;
      if (s[15]) r = r ^ 16'hD008;
      r = r ^ {12'h000, d[0], d[1], d[2], d[3]};
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0; data_valid = 1'b0; shift_en = 1'b0;
      scan_in = 1'b0; data_in = 4'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      cycle();
      checks++; if (a_sig !== 16'hFFFF) begin errors++; $display("FAIL reset_a_sig: got %h want ffff", a_sig); end
      checks++; if ({a_busy, a_done, a_pass, a_fail} !== 4'b0000) begin errors++; $display("FAIL reset_a_flags: got %b want 0000", {a_busy, a_done, a_pass, a_fail}); end
      checks++; if (b_sig !== 16'hFFFF) begin errors++; $display("FAIL reset_b_sig: got %h want ffff", b_sig); end
      checks++; if ({b_busy, b_done, b_pass, b_fail} !== 4'b0000) begin errors++; $display("FAIL reset_b_flags: got %b want 0000", {b_busy, b_done, b_pass, b_fail}); end
      rst = 1'b0;
      // Inputs other than start are ignored in IDLE.
      data_valid = 1'b1; data_in = 4'hF; shift_en = 1'b1; scan_in = 1'b1;
      cycle();
      idle_inputs();
      checks++; if (b_sig !== 16'hFFFF || b_busy !== 1'b0) begin errors++; $display("FAIL idle_ignore: got sig=%h busy=%b want ffff 0", b_sig, b_busy); end
   endtask

   task automatic test_single_vector();
      do_reset();
      start = 1'b1;
      cycle();
      start = 1'b0;
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", a_busy); end
      data_in = 4'h0; data_valid = 1'b1;
      cycle();
      data_valid = 1'b0;
      checks++; if (a_sig !== 16'h2FF6) begin errors++; $display("FAIL single_d0_sig: got %h want 2ff6", a_sig); end
      checks++; if ({a_busy, a_done, a_pass, a_fail} !== 4'b0101) begin errors++; $display("FAIL single_d0_flags: got %b want 0101", {a_busy, a_done, a_pass, a_fail}); end
      // Restart from DONE, then data 4'h8 matches GOLDEN.
      start = 1'b1;
      cycle();
      start = 1'b0;
      checks++; if (a_sig !== 16'hFFFF || a_done !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL single_restart: got sig=%h done=%b busy=%b want ffff 0 1", a_sig, a_done, a_busy); end
      data_in = 4'h8; data_valid = 1'b1;
      cycle();
      data_valid = 1'b0;
      checks++; if (a_sig !== 16'h2FF7) begin errors++; $display("FAIL single_d8_sig: got %h want 2ff7", a_sig); end
      checks++; if ({a_done, a_pass, a_fail} !== 3'b110) begin errors++; $display("FAIL single_d8_flags: got %b want 110", {a_done, a_pass, a_fail}); end
   endtask

   task automatic test_gapped_valid();
      logic [15:0] prev;
      bit          ep;
      do_reset();
      m_sig = 16'hFFFF;
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int k = 0; k < 7; k++) begin
         data_valid = (k % 2 == 0);
         data_in    = 4'($urandom_range(0, 15));
         prev       = m_sig;
         if (data_valid) m_sig = m_step(m_sig, data_in);
         cycle();
         checks++; if (b_sig !== m_sig) begin errors++; $display("FAIL gapped_sig[%0d]: got %h want %h", k, b_sig, m_sig); end
         if (!data_valid) begin
            checks++; if (b_sig !== prev) begin errors++; $display("FAIL gapped_hold[%0d]: got %h want %h", k, b_sig, prev); end
         end
         if (k < 6) begin
            checks++; if ({b_busy, b_done} !== 2'b10) begin errors++; $display("FAIL gapped_busy[%0d]: got busy/done=%b want 10", k, {b_busy, b_done}); end
         end else begin
            ep = (m_sig == GOLDEN_B);
            checks++; if ({b_busy, b_done, b_pass, b_fail} !== {2'b01, ep, !ep}) begin errors++; $display("FAIL gapped_done: got %b want %b", {b_busy, b_done, b_pass, b_fail}, {2'b01, ep, !ep}); end
         end
      end
      data_valid = 1'b0;
   endtask

   task automatic test_unload();
      logic [15:0] w;
      bit          ep;
      ep = (m_sig == GOLDEN_B);
      exp_q.delete();
      w = m_sig;
      for (int j = 0; j < 16; j++) begin
         exp_q.push_back({15'h0, w[15]});
         w = w << 1;
      end
      shift_en = 1'b1; scan_in = 1'b0;
      for (int j = 0; j < 16; j++) begin
         w = exp_q.pop_front();
         checks++; if (b_scan_out !== w[0]) begin errors++; $display("FAIL unload_bit[%0d]: got %b want %b", j, b_scan_out, w[0]); end
         cycle();
         checks++; if ({b_done, b_pass, b_fail} !== {1'b1, ep, !ep}) begin errors++; $display("FAIL unload_flags[%0d]: got %b want %b", j, {b_done, b_pass, b_fail}, {1'b1, ep, !ep}); end
      end
      shift_en = 1'b0;
      checks++; if (b_sig !== 16'h0000) begin errors++; $display("FAIL unload_empty: got %h want 0000", b_sig); end
      cycle();
      checks++; if (b_sig !== 16'h0000 || b_done !== 1'b1) begin errors++; $display("FAIL unload_hold: got sig=%h done=%b want 0000 1", b_sig, b_done); end
      m_sig = 16'h0000;
   endtask

   task automatic test_rst_mid_run();
      do_reset();
      start = 1'b1;
      cycle();
      start = 1'b0;
      data_valid = 1'b1; data_in = 4'($urandom_range(0, 15));
      cycle();
      #3;
      rst = 1'b1;
      #1;
      checks++; if (b_sig !== 16'hFFFF || {b_busy, b_done, b_pass, b_fail} !== 4'b0000) begin errors++; $display("FAIL rst_async: got sig=%h flags=%b want ffff 0000", b_sig, {b_busy, b_done, b_pass, b_fail}); end
      cycle();
      rst = 1'b0;
      cycle();
      data_valid = 1'b0;
      checks++; if (b_sig !== 16'hFFFF || b_busy !== 1'b0) begin errors++; $display("FAIL rst_stays_idle: got sig=%h busy=%b want ffff 0", b_sig, b_busy); end
   endtask

   task automatic test_restart();
      do_reset();
      m_sig = 16'hFFFF;
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         data_valid = 1'b1; data_in = 4'($urandom_range(0, 15));
         cycle();
      end
      // start with data_valid: start wins, counter cleared.
      start = 1'b1; data_valid = 1'b1;
      cycle();
      start = 1'b0; data_valid = 1'b0;
      m_sig = 16'hFFFF;
      checks++; if (b_sig !== 16'hFFFF || {b_busy, b_done} !== 2'b10) begin errors++; $display("FAIL restart_compact: got sig=%h busy/done=%b want ffff 10", b_sig, {b_busy, b_done}); end
      for (int k = 0; k < 4; k++) begin
         data_valid = 1'b1; data_in = 4'($urandom_range(0, 15));
         m_sig = m_step(m_sig, data_in);
         cycle();
         checks++; if (b_done !== (k == 3)) begin errors++; $display("FAIL restart_count[%0d]: got done=%b want %b", k, b_done, k == 3); end
      end
      data_valid = 1'b0;
      checks++; if (b_sig !== m_sig) begin errors++; $display("FAIL restart_sig: got %h want %h", b_sig, m_sig); end
      // start + shift_en in DONE.
      start = 1'b1; shift_en = 1'b1;
      cycle();
      start = 1'b0; shift_en = 1'b0;
      checks++; if (b_sig !== 16'hFFFF || {b_busy, b_done, b_pass, b_fail} !== 4'b1000) begin errors++; $display("FAIL restart_from_done: got sig=%h flags=%b want ffff 1000", b_sig, {b_busy, b_done, b_pass, b_fail}); end
      // Complete a run, enter UNLOAD, then start + shift_en.
      for (int k = 0; k < 4; k++) begin
         data_valid = 1'b1; data_in = 4'($urandom_range(0, 15));
         cycle();
      end
      data_valid = 1'b0; shift_en = 1'b1; scan_in = 1'b1;
      cycle();
      start = 1'b1;
      cycle();
      start = 1'b0; shift_en = 1'b0; scan_in = 1'b0;
      checks++; if (b_sig !== 16'hFFFF || {b_busy, b_done, b_pass, b_fail} !== 4'b1000) begin errors++; $display("FAIL restart_from_unload: got sig=%h flags=%b want ffff 1000", b_sig, {b_busy, b_done, b_pass, b_fail}); end
   endtask

   task automatic test_random_runs();
      int nvalid, iter, n;
      bit ep;
      for (int run = 0; run < 6; run++) begin
         start = 1'b1;
         cycle();
         start = 1'b0;
         m_sig = 16'hFFFF;
         nvalid = 0; iter = 0;
         while (nvalid < 4 && iter < 64) begin
            data_valid = 1'($urandom_range(0, 1));
            data_in    = 4'($urandom_range(0, 15));
            if (data_valid) begin
               m_sig = m_step(m_sig, data_in);
               nvalid++;
            end
            cycle();
            iter++;
            checks++; if (b_sig !== m_sig || b_done !== (nvalid == 4)) begin errors++; $display("FAIL rand_step[%0d.%0d]: got sig=%h done=%b want %h %b", run, iter, b_sig, b_done, m_sig, nvalid == 4); end
         end
         data_valid = 1'b0;
         checks++; if (nvalid != 4) begin errors++; $display("FAIL rand_budget[%0d]: got %0d vectors want 4", run, nvalid); end
         ep = (m_sig == GOLDEN_B);
         checks++; if ({b_pass, b_fail} !== {ep, !ep}) begin errors++; $display("FAIL rand_verdict[%0d]: got %b want %b", run, {b_pass, b_fail}, {ep, !ep}); end
         n = $urandom_range(1, 8);
         for (int j = 0; j < n; j++) begin
            checks++; if (b_scan_out !== m_sig[15]) begin errors++; $display("FAIL rand_scan[%0d.%0d]: got %b want %b", run, j, b_scan_out, m_sig[15]); end
            shift_en = 1'b1; scan_in = 1'($urandom_range(0, 1));
            m_sig = {m_sig[14:0], scan_in};
            cycle();
         end
         shift_en = 1'b0; scan_in = 1'b0;
         cycle();
         checks++; if (b_sig !== m_sig || {b_done, b_pass, b_fail} !== {1'b1, ep, !ep}) begin errors++; $display("FAIL rand_partial[%0d]: got sig=%h flags=%b want %h %b", run, b_sig, {b_done, b_pass, b_fail}, m_sig, {1'b1, ep, !ep}); end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_single_vector();
      test_gapped_valid();
      test_unload();
      test_rst_mid_run();
      test_restart();
      test_random_runs();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "simulation time limit");
   end

endmodule
